// File: rtl/nonrestoring_divider_pkg.sv
// ---------------------------------------------------------------------------
// nonrestoring_divider_pkg
//  Shared definitions for the multi-cycle arithmetic units. The state
//  encoding is common to the divider and to future sequential units (such
//  as the multiplier), so that they all present the same handshake shape.
// ---------------------------------------------------------------------------
package nonrestoring_divider_pkg;

   // Sequencer states of a multi-cycle functional unit.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

endpackage : nonrestoring_divider_pkg

// File: rtl/nonrestoring_divider_div_addsub.sv
// ---------------------------------------------------------------------------
// div_addsub
//  Combinational W-bit adder/subtracter. The result wraps modulo 2^W.
//  Ports:
//   a    in  W  first operand
//   b    in  W  second operand
//   sub  in  1  0: sum = a + b, 1: sum = a - b
//   sum  out W  result
// ---------------------------------------------------------------------------
module div_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum
);

   logic [W-1:0] b_eff;
   logic [W-1:0] cin;

   // Subtraction is a + ~b + 1: sub inverts b and supplies the carry-in.
   assign b_eff = b ^ {W{sub}};
   assign cin   = {{(W-1){1'b0}}, sub};
   assign sum   = a + b_eff + cin;

endmodule : div_addsub

// File: rtl/nonrestoring_divider.sv
// ---------------------------------------------------------------------------
// nonrestoring_divider
//  Sequential unsigned N-bit divider, non-restoring algorithm. It takes one
//  add-or-subtract step per clock on a shared (N+1)-bit datapath, then
//  applies one remainder correction step.
//  Ports:
//   clk          in   1  clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   start        in   1  request, sampled only in IDLE or DONE
//   dividend     in   N  unsigned dividend, sampled with start
//   divisor      in   N  unsigned divisor, sampled with start
//   busy         out  1  high while the iteration is in progress
//   done         out  1  one-cycle pulse, results valid
//   quotient     out  N  result, held until replaced
//   remainder    out  N  result, held until replaced
//   div_by_zero  out  1  set with done when divisor was zero
//  Latency: start accepted at edge k -> done in cycle k+N+2 (k+1 on /0).
// ---------------------------------------------------------------------------
module nonrestoring_divider
   import nonrestoring_divider_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CNT_W = $clog2(N + 1);

   div_state_e   state_q, state_d;
   logic [N:0]   a_q, a_d;           // partial remainder, two's complement
   logic [N-1:0] q_q, q_d;           // dividend shifting out, quotient in
   logic [N:0]   m_q, m_d;           // zero-extended divisor
   logic [CNT_W-1:0] count_q, count_d;
   logic [N-1:0] quotient_q, quotient_d;
   logic [N-1:0] remainder_q, remainder_d;
   logic         dbz_q, dbz_d;

   // Shared add/sub datapath operands.
   logic [N:0]   a_shift;
   logic [N:0]   as_a;
   logic         as_sub;
   logic [N:0]   as_sum;

   // One left shift of the {A,Q} pair: the top bit of Q enters A.
   assign a_shift = {a_q[N-1:0], q_q[N-1]};

   // In RUN the sign of the old A chooses subtract (A >= 0) or add (A < 0).
   // In FIX the same adder restores a negative remainder by adding M back.
   always_comb begin
      as_a   = a_shift;
      as_sub = ~a_q[N];
      if (state_q == S_FIX) begin
         as_a   = a_q;
         as_sub = 1'b0;
      end
   end

   div_addsub #(
      .W (N + 1)
   ) u_addsub (
      .a   (as_a),
      .b   (m_q),
      .sub (as_sub),
      .sum (as_sum)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      q_d         = q_q;
      m_d         = m_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = '0;
               q_d     = dividend;
               m_d     = {1'b0, divisor};
               count_d = CNT_W'(N);
               if (divisor == '0) begin
                  // No iteration needed: results are defined directly.
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  dbz_d   = 1'b0;
                  state_d = S_RUN;
               end
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            a_d     = as_sum;
            // New quotient bit is 1 when the partial remainder stays >= 0.
            q_d     = {q_q[N-2:0], ~as_sum[N]};
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            if (a_q[N]) begin
               a_d = as_sum;
            end
            quotient_d  = q_q;
            remainder_d = a_q[N] ? as_sum[N-1:0] : a_q[N-1:0];
            state_d     = S_DONE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         q_q         <= '0;
         m_q         <= '0;
         count_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         q_q         <= q_d;
         m_q         <= m_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule : nonrestoring_divider
